// File: rtl/lsq_scheduler_pkg.sv
// Shared definitions for the load/store queue: FSM states, access-size codes
// and entry field widths.
package lsq_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } lsq_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned REGD_W   = 5;
  localparam int unsigned FUNCT3_W = 3;

endpackage

// File: rtl/lsq_fifo.sv
// Parameterised synchronous FIFO holding queued memory operations; all state
// freezes while clk_en_i is low.
module lsq_fifo #(
  parameter int unsigned C_DEPTH_X = 2,
  parameter int unsigned C_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 clk_en_i,
  input  logic                 resetb_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [C_WIDTH-1:0]   data_i,
  output logic [C_WIDTH-1:0]   data_o,
  output logic [C_DEPTH_X:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned DEPTH = 2**C_DEPTH_X;

  logic [C_WIDTH-1:0]   mem_q [DEPTH];
  logic [C_DEPTH_X-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_DEPTH_X:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (C_DEPTH_X+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push while full is still taken when the head leaves in the same cycle.
  always_comb begin
    do_pop   = clk_en_i && pop_i && !empty_o;
    do_push  = clk_en_i && push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + C_DEPTH_X'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + C_DEPTH_X'(1);
    if (do_push && !do_pop)      count_d = count_q + (C_DEPTH_X+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (C_DEPTH_X+1)'(1);
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!resetb_i)
    !(clk_en_i && push_i && full_o && !do_pop));

endmodule

// File: rtl/lsq_scheduler.sv
// Load/store queue: issues queued ops one at a time on the data bus and writes
// back lane-extracted load data. Define LSQ_ERR_REPORT_EN for access-fault reporting.
module lsq_scheduler
  import lsq_scheduler_pkg::*;
#(
  parameter int unsigned C_XLEN_X  = 5,
  parameter int unsigned C_XLEN    = 2**C_XLEN_X,
  parameter int unsigned C_DEPTH_X = 2
) (
  input  logic                clk_i,
  input  logic                clk_en_i,
  input  logic                resetb_i,
  input  logic                ex_lq_wr_i,
  input  logic                ex_sq_wr_i,
  input  logic [2:0]          ex_funct3_i,
  input  logic [4:0]          ex_regd_addr_i,
  input  logic [C_XLEN-1:0]   ex_regs2_data_i,
  input  logic [C_XLEN-1:0]   ex_addr_i,
  output logic                ex_full_o,
  output logic                lsq_empty_o,
  output logic                dbus_req_o,
  output logic                dbus_we_o,
  output logic [C_XLEN-1:0]   dbus_addr_o,
  output logic [C_XLEN/8-1:0] dbus_be_o,
  output logic [C_XLEN-1:0]   dbus_wdata_o,
  input  logic                dbus_gnt_i,
  input  logic                dbus_rvalid_i,
  input  logic [C_XLEN-1:0]   dbus_rdata_i,
  input  logic                dbus_err_i,
  output logic                wb_regd_wr_o,
  output logic [4:0]          wb_regd_addr_o,
  output logic [C_XLEN-1:0]   wb_regd_data_o,
  output logic                hvec_laf_o,
  output logic                hvec_saf_o,
  output logic [C_XLEN-1:0]   hvec_fault_addr_o
);

  localparam int unsigned BW = C_XLEN / 8;

  typedef struct packed {
    logic                we;
    logic [FUNCT3_W-1:0] funct3;
    logic [REGD_W-1:0]   regd;
    logic [C_XLEN-1:0]   addr;
    logic [C_XLEN-1:0]   data;
  } entry_t;

  entry_t             push_ent, head;
  logic               push_req, pop, fifo_full, fifo_empty;
  logic [C_DEPTH_X:0] fifo_count;
  lsq_state_e         state_q, state_d;
  logic               rsp, rsp_err;
  logic [C_XLEN-1:0]  ld_shift, ld_data;
  logic               wb_wr_q, wb_wr_d;
  logic [REGD_W-1:0]  wb_addr_q, wb_addr_d;
  logic [C_XLEN-1:0]  wb_data_q, wb_data_d;

  assign push_req = ex_lq_wr_i | ex_sq_wr_i;
  assign push_ent = '{we: ex_sq_wr_i, funct3: ex_funct3_i, regd: ex_regd_addr_i,
                      addr: ex_addr_i, data: ex_regs2_data_i};

  lsq_fifo #(
    .C_DEPTH_X (C_DEPTH_X),
    .C_WIDTH   ($bits(entry_t))
  ) u_fifo (
    .clk_i    (clk_i),
    .clk_en_i (clk_en_i),
    .resetb_i (resetb_i),
    .push_i   (push_req),
    .pop_i    (pop),
    .data_i   (push_ent),
    .data_o   (head),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign ex_full_o   = fifo_full;
  assign lsq_empty_o = fifo_empty && (state_q == ST_IDLE);
  assign rsp         = (state_q == ST_WAIT) && dbus_rvalid_i;

  // Leaving IDLE on the accepting push edge gives request one cycle after the push.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (fifo_count != '0 || (push_req && !fifo_full)) state_d = ST_REQ;
      ST_REQ:  if (dbus_gnt_i) state_d = ST_WAIT;
      ST_WAIT: if (dbus_rvalid_i) begin
        pop     = 1'b1;
        state_d = (fifo_count > (C_DEPTH_X+1)'(1) || push_req) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    if (state_q == ST_REQ) begin
      dbus_req_o  = 1'b1;
      dbus_we_o   = head.we;
      dbus_addr_o = {head.addr[C_XLEN-1:2], 2'b00};
      case (head.funct3[1:0])
        SZ_B: begin
          dbus_be_o    = BW'(1) << head.addr[1:0];
          dbus_wdata_o = {BW{head.data[7:0]}};
        end
        SZ_H: begin
          dbus_be_o    = BW'(3) << {head.addr[1], 1'b0};
          dbus_wdata_o = {(BW/2){head.data[15:0]}};
        end
        default: begin
          dbus_be_o    = '1;
          dbus_wdata_o = head.data;
        end
      endcase
    end
  end

  always_comb begin
    ld_shift = dbus_rdata_i >> {head.addr[1:0], 3'b000};
    case (head.funct3[1:0])
      SZ_B:    ld_data = {{(C_XLEN-8){ld_shift[7] & ~head.funct3[2]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{(C_XLEN-16){ld_shift[15] & ~head.funct3[2]}}, ld_shift[15:0]};
      default: ld_data = dbus_rdata_i;
    endcase
    wb_wr_d   = rsp && !head.we && (head.regd != '0) && !rsp_err;
    wb_addr_d = wb_wr_d ? head.regd : wb_addr_q;
    wb_data_d = wb_wr_d ? ld_data : wb_data_q;
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= ST_IDLE;
      wb_wr_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (clk_en_i) begin
      state_q   <= state_d;
      wb_wr_q   <= wb_wr_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_regd_wr_o   = wb_wr_q;
  assign wb_regd_addr_o = wb_addr_q;
  assign wb_regd_data_o = wb_data_q;

`ifdef LSQ_ERR_REPORT_EN
  logic              laf_q, laf_d, saf_q, saf_d;
  logic [C_XLEN-1:0] fault_addr_q, fault_addr_d;

  assign rsp_err = rsp & dbus_err_i;

  always_comb begin
    laf_d        = rsp_err & ~head.we;
    saf_d        = rsp_err & head.we;
    fault_addr_d = rsp_err ? head.addr : fault_addr_q;
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      laf_q        <= 1'b0;
      saf_q        <= 1'b0;
      fault_addr_q <= '0;
    end else if (clk_en_i) begin
      laf_q        <= laf_d;
      saf_q        <= saf_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign hvec_laf_o        = laf_q;
  assign hvec_saf_o        = saf_q;
  assign hvec_fault_addr_o = fault_addr_q;
`else
  logic err_unused;
  assign err_unused        = dbus_err_i;
  assign rsp_err           = 1'b0;
  assign hvec_laf_o        = 1'b0;
  assign hvec_saf_o        = 1'b0;
  assign hvec_fault_addr_o = '0;
`endif

endmodule

// File: tb/tb_lsq_scheduler.sv
// Self-checking bench for lsq_scheduler: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_lsq_scheduler;

  logic        clk_i = 1'b0;
  logic        clk_en_i, resetb_i, ex_lq_wr_i, ex_sq_wr_i;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_regd_addr_i;
  logic [31:0] ex_regs2_data_i, ex_addr_i;
  logic        ex_full_o, lsq_empty_o, dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
  logic [31:0] dbus_rdata_i;
  logic        wb_regd_wr_o;
  logic [4:0]  wb_regd_addr_o;
  logic [31:0] wb_regd_data_o;
  logic        hvec_laf_o, hvec_saf_o;
  logic [31:0] hvec_fault_addr_o;

  lsq_scheduler dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i), .ex_funct3_i(ex_funct3_i),
    .ex_regd_addr_i(ex_regd_addr_i), .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
    .ex_full_o(ex_full_o), .lsq_empty_o(lsq_empty_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
    .wb_regd_wr_o(wb_regd_wr_o), .wb_regd_addr_o(wb_regd_addr_o), .wb_regd_data_o(wb_regd_data_o),
    .hvec_laf_o(hvec_laf_o), .hvec_saf_o(hvec_saf_o), .hvec_fault_addr_o(hvec_fault_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    ent_t        e;
    logic [31:0] rdata;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_wb;
    logic [31:0] x_wb_data;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ent_t        q[$];
  bit          outstanding;
  bit          x_wb;
  logic [4:0]  x_wb_addr;
  logic [31:0] x_wb_data;
`ifdef LSQ_ERR_REPORT_EN
  bit          x_laf, x_saf;
  logic [31:0] x_faddr;
`endif
  ent_t        nil = '0;
  vec_t        vt[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned nbytes(input ent_t e);
    return (e.f3[1:0] == 2'b00) ? 1 : (e.f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input ent_t e);
    int unsigned n = nbytes(e);
    int unsigned base = e.addr[1:0];
    logic [3:0] be = '0;
    base = base - (base % n);
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input ent_t e);
    int unsigned n = nbytes(e);
    logic [31:0] w;
    for (int unsigned i = 0; i < 4; i++) w[8*i +: 8] = e.data[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input ent_t e, input logic [31:0] rd);
    int unsigned n = nbytes(e);
    int unsigned off = e.addr[1:0];
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!e.f3[2] && n < 4 && v[8*n-1])
      for (int unsigned i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    int unsigned sz = $urandom_range(0, 2);
    e.we   = ($urandom_range(0, 1) == 1);
    e.f3   = {(!e.we && sz < 2 && $urandom_range(0, 1) == 1), 2'(sz)};
    e.rd   = 5'($urandom_range(0, 31));
    e.addr = $urandom;
    if (sz == 1) e.addr[0] = 1'b0;
    if (sz == 2) e.addr[1:0] = 2'b00;
    e.data = $urandom;
    return e;
  endfunction

  function automatic vec_t mkv(input bit we, input bit [2:0] f3, input bit [4:0] rd,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] rdata, input logic [31:0] xa,
                               input logic [3:0] xbe, input logic [31:0] xwd,
                               input bit xwb, input logic [31:0] xwbd);
    vec_t v;
    v.e = '{we: we, f3: f3, rd: rd, addr: addr, data: data};
    v.rdata = rdata; v.x_addr = xa; v.x_be = xbe; v.x_wdata = xwd;
    v.x_wb = xwb; v.x_wb_data = xwbd;
    return v;
  endfunction

  task automatic check_all();
    bit rq = (q.size() != 0) && !outstanding;
    cmp("full", ex_full_o, q.size() == 4);
    cmp("empty", lsq_empty_o, (q.size() == 0) && !outstanding);
    cmp("req", dbus_req_o, rq);
    if (rq) begin
      cmp("we", dbus_we_o, q[0].we);
      cmp("addr", dbus_addr_o, {q[0].addr[31:2], 2'b00});
      cmp("be", dbus_be_o, m_be(q[0]));
      if (q[0].we) cmp("wdata", dbus_wdata_o, m_wdata(q[0]));
    end
    cmp("wb_wr", wb_regd_wr_o, x_wb);
    if (x_wb) begin
      cmp("wb_addr", wb_regd_addr_o, x_wb_addr);
      cmp("wb_data", wb_regd_data_o, x_wb_data);
    end
`ifdef LSQ_ERR_REPORT_EN
    cmp("laf", hvec_laf_o, x_laf);
    cmp("saf", hvec_saf_o, x_saf);
    if (x_laf || x_saf) cmp("fault_addr", hvec_fault_addr_o, x_faddr);
`else
    cmp("laf_tied", hvec_laf_o, 0);
    cmp("saf_tied", hvec_saf_o, 0);
    cmp("faddr_tied", hvec_fault_addr_o, 0);
`endif
  endtask

  // One clock: drive inputs, advance the model for this edge, then check.
  task automatic step(input bit push, input ent_t e, input bit gnt, input bit rv,
                      input logic [31:0] rd, input bit er, input bit en);
    bit popping = en && rv && outstanding;
    ent_t h;
    if (en && push && q.size() == 4 && !popping) push = 0;
    clk_en_i = en; ex_lq_wr_i = push && !e.we; ex_sq_wr_i = push && e.we;
    ex_funct3_i = e.f3; ex_regd_addr_i = e.rd; ex_addr_i = e.addr; ex_regs2_data_i = e.data;
    dbus_gnt_i = gnt; dbus_rvalid_i = rv; dbus_rdata_i = rd; dbus_err_i = er;
    if (en) begin
      x_wb = 0;
`ifdef LSQ_ERR_REPORT_EN
      x_laf = 0; x_saf = 0;
`endif
      if (popping) begin
        h = q.pop_front();
        outstanding = 0;
`ifdef LSQ_ERR_REPORT_EN
        if (er) begin x_laf = !h.we; x_saf = h.we; x_faddr = h.addr; end
        else
`endif
        if (!h.we && h.rd != 0) begin x_wb = 1; x_wb_addr = h.rd; x_wb_data = m_load(h, rd); end
      end else if (gnt && q.size() != 0 && !outstanding) outstanding = 1;
      if (push && q.size() < 4) q.push_back(e);
    end
    @(posedge clk_i); #1;
    check_all();
  endtask

  task automatic idle();
    step(0, nil, 0, 0, '0, 0, 1);
  endtask

  task automatic model_clear();
    q.delete(); outstanding = 0; x_wb = 0;
`ifdef LSQ_ERR_REPORT_EN
    x_laf = 0; x_saf = 0;
`endif
  endtask

  task automatic check_reset_outputs();
    cmp("rst_full", ex_full_o, 0);       cmp("rst_empty", lsq_empty_o, 1);
    cmp("rst_req", dbus_req_o, 0);       cmp("rst_we", dbus_we_o, 0);
    cmp("rst_addr", dbus_addr_o, 0);     cmp("rst_be", dbus_be_o, 0);
    cmp("rst_wdata", dbus_wdata_o, 0);   cmp("rst_wb", wb_regd_wr_o, 0);
    cmp("rst_wb_addr", wb_regd_addr_o, 0); cmp("rst_wb_data", wb_regd_data_o, 0);
    cmp("rst_laf", hvec_laf_o, 0);       cmp("rst_saf", hvec_saf_o, 0);
  endtask

  initial begin
    resetb_i = 0; clk_en_i = 1; ex_lq_wr_i = 0; ex_sq_wr_i = 0; ex_funct3_i = 0;
    ex_regd_addr_i = 0; ex_regs2_data_i = 0; ex_addr_i = 0;
    dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0; dbus_err_i = 0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1 check_reset_outputs();
    resetb_i = 1;
    idle();

    // we f3 rd addr data rdata | addr be wdata wb wb_data
    vt.push_back(mkv(1, 3'b010, 0, 32'h100, 32'hDEADBEEF, 0, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0));
    vt.push_back(mkv(0, 3'b000, 5, 32'h103, 0, 32'h80112233, 32'h100, 4'h8, 0, 1, 32'hFFFFFF80));
    vt.push_back(mkv(0, 3'b100, 5, 32'h103, 0, 32'h80112233, 32'h100, 4'h8, 0, 1, 32'h00000080));
    vt.push_back(mkv(0, 3'b101, 6, 32'h102, 0, 32'h80112233, 32'h100, 4'hC, 0, 1, 32'h00008011));
    vt.push_back(mkv(0, 3'b001, 7, 32'h102, 0, 32'h80112233, 32'h100, 4'hC, 0, 1, 32'hFFFF8011));
    vt.push_back(mkv(1, 3'b000, 0, 32'h201, 32'h000000A5, 0, 32'h200, 4'h2, 32'hA5A5A5A5, 0, 0));
    vt.push_back(mkv(1, 3'b001, 0, 32'h20E, 32'h1234BEEF, 0, 32'h20C, 4'hC, 32'hBEEFBEEF, 0, 0));
    vt.push_back(mkv(0, 3'b010, 0, 32'h300, 0, 32'h12345678, 32'h300, 4'hF, 0, 0, 0));
    vt.push_back(mkv(0, 3'b000, 9, 32'h110, 0, 32'h0000007F, 32'h110, 4'h1, 0, 1, 32'h0000007F));
    vt.push_back(mkv(0, 3'b010, 31, 32'h44, 0, 32'hCAFEF00D, 32'h44, 4'hF, 0, 1, 32'hCAFEF00D));
    vt.push_back(mkv(0, 3'b001, 4, 32'h100, 0, 32'h1234F00D, 32'h100, 4'h3, 0, 1, 32'hFFFFF00D));

    for (int unsigned k = 0; k < vt.size(); k++) begin
      step(1, vt[k].e, 0, 0, '0, 0, 1);
      cmp("v_req", dbus_req_o, 1);
      cmp("v_addr", dbus_addr_o, vt[k].x_addr);
      cmp("v_be", dbus_be_o, vt[k].x_be);
      if (vt[k].e.we) cmp("v_wdata", dbus_wdata_o, vt[k].x_wdata);
      step(0, nil, 1, 0, '0, 0, 1);
      idle();
      step(0, nil, 0, 1, vt[k].rdata, 0, 1);
      cmp("v_wb", wb_regd_wr_o, vt[k].x_wb);
      if (vt[k].x_wb) begin
        cmp("v_wb_addr", wb_regd_addr_o, vt[k].e.rd);
        cmp("v_wb_data", wb_regd_data_o, vt[k].x_wb_data);
      end
      idle();
    end

    // Fill to full with the bus stalled, then push into the pop cycle.
    for (int unsigned i = 0; i < 4; i++)
      step(1, '{we: 1, f3: 3'b010, rd: 0, addr: 32'h400 + 4*i, data: 32'hA0 + i}, 0, 0, '0, 0, 1);
    cmp("full_after_4", ex_full_o, 1);
    idle(); idle();
    cmp("held_addr", dbus_addr_o, 32'h400);
    step(0, nil, 1, 0, '0, 0, 1);
    cmp("full_in_wait", ex_full_o, 1);
    step(1, '{we: 1, f3: 3'b010, rd: 0, addr: 32'h500, data: 32'h55}, 0, 1, '0, 0, 1);
    cmp("full_after_pushpop", ex_full_o, 1);
    begin
      logic [31:0] order [4] = '{32'h404, 32'h408, 32'h40C, 32'h500};
      for (int unsigned i = 0; i < 4; i++) begin
        cmp("drain_addr", dbus_addr_o, order[i]);
        step(0, nil, 1, 0, '0, 0, 1);
        step(0, nil, 0, 1, '0, 0, 1);
      end
    end
    cmp("drained_empty", lsq_empty_o, 1);

    // Reset while waiting for a response; the late response must be ignored.
    step(1, '{we: 0, f3: 3'b010, rd: 3, addr: 32'h40, data: 0}, 0, 0, '0, 0, 1);
    step(0, nil, 1, 0, '0, 0, 1);
    idle();
    #2 resetb_i = 0;
    #1 check_reset_outputs();
    model_clear();
    #1 resetb_i = 1;
    step(0, nil, 0, 1, 32'h12345678, 0, 1);
    cmp("late_rsp_no_wb", wb_regd_wr_o, 0);
    idle();
    cmp("late_rsp_no_wb2", wb_regd_wr_o, 0);

`ifdef LSQ_ERR_REPORT_EN
    step(1, '{we: 0, f3: 3'b010, rd: 8, addr: 32'h200, data: 0}, 0, 0, '0, 0, 1);
    step(0, nil, 1, 0, '0, 0, 1);
    step(0, nil, 0, 1, 32'h11111111, 1, 1);
    cmp("err_laf", hvec_laf_o, 1);
    cmp("err_faddr", hvec_fault_addr_o, 32'h200);
    cmp("err_no_wb", wb_regd_wr_o, 0);
    idle();
    cmp("err_laf_pulse", hvec_laf_o, 0);
    step(1, '{we: 1, f3: 3'b000, rd: 0, addr: 32'h333, data: 1}, 0, 0, '0, 0, 1);
    step(0, nil, 1, 0, '0, 0, 1);
    step(0, nil, 0, 1, '0, 1, 1);
    cmp("err_saf", hvec_saf_o, 1);
    cmp("err_saf_addr", hvec_fault_addr_o, 32'h333);
    idle();
`endif

    for (int unsigned c = 0; c < 3000; c++) begin
      bit en, push, gnt, rv, er;
      en   = ($urandom_range(0, 7) != 0);
      push = ($urandom_range(0, 2) == 0);
      gnt  = ($urandom_range(0, 1) == 0);
      rv   = outstanding ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      er   = ($urandom_range(0, 5) == 0);
      step(push, rnd_ent(), gnt, rv, $urandom, er, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
